// File: rtl/banked_bus_memory.sv
// rtl/banked_bus_memory.sv - banked data-bus memory peripheral with wait states and bank-select register
//
// Ports:
//   clk       bus clock, rising edge
//   reset     synchronous active-high reset
//   addr      request address, held by the requester until ready
//   wdata     write data
//   rd, wr    read / write request strobes
//   rdata     read data, valid while ready=1
//   rdata_oe  drive enable for rdata on the shared bus
//   ready     one-cycle completion pulse
//   err       one-cycle pulse on rd&wr to a mapped address
//   bank      current bank-select register
module banked_bus_memory #(
    parameter int               DATA_SIZE     = 8,
    parameter int               ADDR_SIZE     = 16,
    parameter int               DEPTH         = 256,
    parameter logic [ADDR_SIZE-1:0] BASE_ADDR = 16'hC000,
    parameter int               NUM_BANKS     = 4,
    parameter int               WAIT_STATES   = 0,
    parameter logic [ADDR_SIZE-1:0] BANK_REG_ADDR = 16'hBFFF,
    localparam int              BW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ADDR_SIZE-1:0] addr,
    input  logic [DATA_SIZE-1:0] wdata,
    input  logic                 rd,
    input  logic                 wr,
    output logic [DATA_SIZE-1:0] rdata,
    output logic                 rdata_oe,
    output logic                 ready,
    output logic                 err,
    output logic [BW-1:0]        bank
);

    localparam int OW = $clog2(DEPTH);
    localparam int IW = $clog2(NUM_BANKS * DEPTH);
    localparam logic [ADDR_SIZE-1:0] DECODER_MASK = ADDR_SIZE'(DEPTH - 1);
    localparam logic [3:0] LAST_COUNT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    state_t               state;
    logic [3:0]           count;
    logic [DATA_SIZE-1:0] mem [NUM_BANKS * DEPTH];

    // Latched request, used once the FSM has left IDLE
    logic [OW-1:0]        lat_off;
    logic [DATA_SIZE-1:0] lat_wdata;
    logic                 lat_wr;
    logic                 lat_reg;
    logic [BW-1:0]        lat_bank;

    logic hit_mem, hit_reg, hit, accept;
    assign hit_mem = (addr & ~DECODER_MASK) == BASE_ADDR;
    assign hit_reg = addr == BANK_REG_ADDR;
    assign hit     = hit_mem | hit_reg;
    assign accept  = (rd ^ wr) & hit;

    // With zero wait states the access completes on the accept edge itself,
    // so the access fields come straight from the bus rather than the latches.
    logic                 go_done;
    logic [OW-1:0]        acc_off;
    logic [DATA_SIZE-1:0] acc_wdata;
    logic                 acc_wr;
    logic                 acc_reg;
    logic [BW-1:0]        acc_bank;
    logic [IW-1:0]        mem_idx;

    always_comb begin
        go_done   = 1'b0;
        acc_off   = lat_off;
        acc_wdata = lat_wdata;
        acc_wr    = lat_wr;
        acc_reg   = lat_reg;
        acc_bank  = lat_bank;
        if (state == IDLE) begin
            go_done   = accept && (WAIT_STATES == 0);
            acc_off   = addr[OW-1:0];
            acc_wdata = wdata;
            acc_wr    = wr;
            acc_reg   = hit_reg;
            acc_bank  = bank;
        end else if (state == WAIT) begin
            go_done = count == LAST_COUNT;
        end
    end

    generate
        if (NUM_BANKS > 1) begin : g_banked
            assign mem_idx = IW'({acc_bank, acc_off});
        end else begin : g_single
            assign mem_idx = IW'(acc_off);
        end
    endgenerate

    // RAM is not reset; a reset edge blocks any pending commit
    always_ff @(posedge clk) begin
        if (!reset && go_done && acc_wr && !acc_reg) begin
            mem[mem_idx] <= acc_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            count     <= 4'd0;
            ready     <= 1'b0;
            rdata_oe  <= 1'b0;
            err       <= 1'b0;
            rdata     <= '0;
            bank      <= '0;
            lat_off   <= '0;
            lat_wdata <= '0;
            lat_wr    <= 1'b0;
            lat_reg   <= 1'b0;
            lat_bank  <= '0;
        end else begin
            ready    <= 1'b0;
            rdata_oe <= 1'b0;
            err      <= 1'b0;
            case (state)
                IDLE: begin
                    if (rd && wr && hit) begin
                        err <= 1'b1;
                    end else if (accept) begin
                        lat_off   <= addr[OW-1:0];
                        lat_wdata <= wdata;
                        lat_wr    <= wr;
                        lat_reg   <= hit_reg;
                        lat_bank  <= bank;
                        count     <= 4'd0;
                        state     <= (WAIT_STATES == 0) ? DONE : WAIT;
                    end
                end
                WAIT: begin
                    if (count == LAST_COUNT) begin
                        state <= DONE;
                    end else begin
                        count <= count + 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            // Outputs are registered on the edge that enters DONE, so they
            // are visible for exactly the DONE cycle.
            if (go_done) begin
                ready <= 1'b1;
                if (acc_wr) begin
                    if (acc_reg) begin
                        bank <= (NUM_BANKS > 1) ? BW'(acc_wdata) : '0;
                    end
                end else begin
                    rdata_oe <= 1'b1;
                    rdata    <= acc_reg ? DATA_SIZE'(bank) : mem[mem_idx];
                end
            end
        end
    end

endmodule
